// File: rtl/div_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// div_ctrl : EXE-stage handshake controller for an AXI-stream divider IP.
// Rev 1.0
// ---------------------------------------------------------------------------
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic        div_op,
    input  logic        divu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    input  logic        es_leave,
    output logic        dvd_tvalid,
    input  logic        dvd_tready,
    output logic [31:0] dvd_tdata,
    output logic        dvs_tvalid,
    input  logic        dvs_tready,
    output logic [31:0] dvs_tdata,
    output logic        div_signed,
    input  logic        dout_tvalid,
    input  logic [63:0] dout_tdata,
    output logic        div_ready_go,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_dvd_sent;
    logic        r_dvs_sent;
    logic [31:0] r_dvd_tdata;
    logic [31:0] r_dvs_tdata;
    logic        r_div_signed;
    logic        r_we;
    logic [31:0] r_hi_wdata;
    logic [31:0] r_lo_wdata;

    logic w_start;
    logic w_in_xfer;
    logic w_dvd_done;
    logic w_dvs_done;
    logic w_wr;

    assign w_start    = (r_state == S_IDLE) & es_valid & (div_op | divu_op) & ~flush;
    assign w_in_xfer  = (r_state == S_SEND) | (r_state == S_DRAIN);
    assign dvd_tvalid = w_in_xfer & ~r_dvd_sent;
    assign dvs_tvalid = w_in_xfer & ~r_dvs_sent;
    // A channel counts as done if it was accepted earlier or is accepted on this edge.
    assign w_dvd_done = r_dvd_sent | (dvd_tvalid & dvd_tready);
    assign w_dvs_done = r_dvs_sent | (dvs_tvalid & dvs_tready);
    assign w_wr       = (r_state == S_WAIT) & dout_tvalid & ~flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SEND;
            S_SEND: begin
                // Once any operand reached the IP, its result must be absorbed.
                if (flush)
                    w_next = (w_dvd_done | w_dvs_done) ? S_DRAIN : S_IDLE;
                else if (w_dvd_done & w_dvs_done)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush)
                    w_next = dout_tvalid ? S_IDLE : S_DRAIN;
                else if (dout_tvalid)
                    w_next = S_DONE;
            end
            S_DONE:  if (es_leave | flush) w_next = S_IDLE;
            S_DRAIN: if (r_dvd_sent & r_dvs_sent & dout_tvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dvd_sent   <= 1'b0;
            r_dvs_sent   <= 1'b0;
            r_dvd_tdata  <= 32'd0;
            r_dvs_tdata  <= 32'd0;
            r_div_signed <= 1'b0;
            r_we         <= 1'b0;
            r_hi_wdata   <= 32'd0;
            r_lo_wdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_we    <= w_wr;
            if (w_wr) begin
                r_lo_wdata <= dout_tdata[63:32];
                r_hi_wdata <= dout_tdata[31:0];
            end
            if (w_start) begin
                r_dvd_tdata  <= src1;
                r_dvs_tdata  <= src2;
                r_div_signed <= div_op;
                r_dvd_sent   <= 1'b0;
                r_dvs_sent   <= 1'b0;
            end else if (w_in_xfer) begin
                r_dvd_sent <= w_dvd_done;
                r_dvs_sent <= w_dvs_done;
            end
        end
    end

    assign dvd_tdata    = r_dvd_tdata;
    assign dvs_tdata    = r_dvs_tdata;
    assign div_signed   = r_div_signed;
    assign hi_we        = r_we;
    assign lo_we        = r_we;
    assign hi_wdata     = r_hi_wdata;
    assign lo_wdata     = r_lo_wdata;
    assign div_ready_go = (r_state == S_DONE) | ~(div_op | divu_op);

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_div_ctrl : directed self-checking bench for div_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid, div_op, divu_op, flush, es_leave;
    logic [31:0] src1, src2;
    logic        dvd_tvalid, dvd_tready, dvs_tvalid, dvs_tready;
    logic [31:0] dvd_tdata, dvs_tdata;
    logic        div_signed;
    logic        dout_tvalid;
    logic [63:0] dout_tdata;
    logic        div_ready_go, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .es_valid     (es_valid),
        .div_op       (div_op),
        .divu_op      (divu_op),
        .src1         (src1),
        .src2         (src2),
        .flush        (flush),
        .es_leave     (es_leave),
        .dvd_tvalid   (dvd_tvalid),
        .dvd_tready   (dvd_tready),
        .dvd_tdata    (dvd_tdata),
        .dvs_tvalid   (dvs_tvalid),
        .dvs_tready   (dvs_tready),
        .dvs_tdata    (dvs_tdata),
        .div_signed   (div_signed),
        .dout_tvalid  (dout_tvalid),
        .dout_tdata   (dout_tdata),
        .div_ready_go (div_ready_go),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
        es_valid = 1'b1;
        div_op   = is_signed;
        divu_op  = ~is_signed;
        src1     = a;
        src2     = b;
    endtask

    task automatic clear_ins();
        es_valid = 1'b0;
        div_op   = 1'b0;
        divu_op  = 1'b0;
    endtask

    task automatic give_result(input logic [63:0] d);
        dout_tvalid = 1'b1;
        dout_tdata  = d;
        step();
        dout_tvalid = 1'b0;
    endtask

    task automatic leave();
        es_leave = 1'b1;
        step();
        es_leave = 1'b0;
        clear_ins();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        es_valid = 0; div_op = 0; divu_op = 0; flush = 0; es_leave = 0;
        src1 = 0; src2 = 0; dvd_tready = 0; dvs_tready = 0;
        dout_tvalid = 0; dout_tdata = 64'd0;
        step();
        step();

        // Reset state
        chk("rst_ctrl", {dvd_tvalid, dvs_tvalid, hi_we, lo_we, div_signed}, 5'b00000);
        chk("rst_data", {dvd_tdata, dvs_tdata}, 64'd0);
        chk("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
        chk("rst_go", div_ready_go, 1'b1);
        reset = 1'b0;
        step();

        // Non-div instruction
        es_valid = 1'b1;
        #1 chk("nondiv_go", div_ready_go, 1'b1);
        step();
        step();
        chk("nondiv_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);
        clear_ins();

        // DIV -7 / 2, both channels ready; DONE held 5 cycles
        dvd_tready = 1'b1;
        dvs_tready = 1'b1;
        start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        #1 chk("t2_go_idle", div_ready_go, 1'b0);
        step();
        chk("t2_send_tv", {dvd_tvalid, dvs_tvalid}, 2'b11);
        chk("t2_send_data", {dvd_tdata, dvs_tdata}, {32'hFFFF_FFF9, 32'h0000_0002});
        chk("t2_signed", div_signed, 1'b1);
        chk("t2_go_send", div_ready_go, 1'b0);
        step();
        chk("t2_wait_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);
        chk("t2_go_wait", div_ready_go, 1'b0);
        for (int i = 0; i < 4; i++) step();
        give_result({32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("t2_lo", lo_wdata, 32'hFFFF_FFFD);
        chk("t2_hi", hi_wdata, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("t2_done_we", {hi_we, lo_we}, (i == 0) ? 2'b11 : 2'b00);
            chk("t2_done_hold", {dvd_tvalid, dvs_tvalid, div_ready_go}, 3'b001);
            if (i < 4) step();
        end
        leave();
        #1 chk("t2_idle", {dvd_tvalid, dvs_tvalid, div_ready_go}, 3'b001);
        step();
        chk("t2_no_restart", {dvd_tvalid, dvs_tvalid}, 2'b00);

        // DIVU 0xFFFFFFFF / 0x10, divisor accepted 3 cycles after dividend
        dvd_tready = 1'b1;
        dvs_tready = 1'b0;
        start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
        step();
        chk("t3_send_tv", {dvd_tvalid, dvs_tvalid}, 2'b11);
        chk("t3_signed", div_signed, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t3_dvs_hold", {dvd_tvalid, dvs_tvalid}, 2'b01);
            chk("t3_dvs_data", dvs_tdata, 32'h0000_0010);
            if (i == 2) dvs_tready = 1'b1;
            step();
        end
        chk("t3_wait_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);
        give_result({32'h0FFF_FFFF, 32'h0000_000F});
        chk("t3_we", {hi_we, lo_we}, 2'b11);
        chk("t3_lo_hi", {lo_wdata, hi_wdata}, {32'h0FFF_FFFF, 32'h0000_000F});
        step();
        chk("t3_we_off", {hi_we, lo_we}, 2'b00);
        leave();

        // Flush in WAIT, result 4 cycles later is discarded, next DIV normal
        start_op(1'b1, 32'd50, 32'd5);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        start_op(1'b1, 32'd100, 32'd7);
        #1 chk("t4_drain_go", div_ready_go, 1'b0);
        chk("t4_drain_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_we", {hi_we, lo_we}, 2'b00);
            step();
        end
        give_result({32'd99, 32'd99});
        chk("t4_nowrite", {hi_we, lo_we}, 2'b00);
        chk("t4_lo_kept", lo_wdata, 32'h0FFF_FFFF);
        chk("t4_idle_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);
        step();
        chk("t4_new_send", {dvd_tvalid, dvs_tvalid}, 2'b11);
        chk("t4_new_data", dvd_tdata, 32'd100);
        step();
        give_result({32'd14, 32'd2});
        chk("t4_new_we", {hi_we, lo_we}, 2'b11);
        chk("t4_new_lo_hi", {lo_wdata, hi_wdata}, {32'd14, 32'd2});
        leave();

        // Flush together with dout_tvalid in WAIT
        start_op(1'b0, 32'd9, 32'd3);
        step();
        step();
        flush = 1'b1;
        give_result({32'd3, 32'd0});
        flush = 1'b0;
        clear_ins();
        chk("t5_nowrite", {hi_we, lo_we}, 2'b00);
        chk("t5_lo_kept", lo_wdata, 32'd14);
        start_op(1'b0, 32'd8, 32'd2);
        step();
        chk("t5_restart", {dvd_tvalid, dvs_tvalid}, 2'b11);
        step();
        give_result({32'd4, 32'd0});
        chk("t5_lo", lo_wdata, 32'd4);
        leave();

        // Flush in SEND with nothing accepted
        dvd_tready = 1'b0;
        dvs_tready = 1'b0;
        start_op(1'b1, 32'd5, 32'd1);
        step();
        chk("t6_send_tv", {dvd_tvalid, dvs_tvalid}, 2'b11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_ins();
        chk("t6_dropped", {dvd_tvalid, dvs_tvalid}, 2'b00);
        step();
        chk("t6_idle", {dvd_tvalid, dvs_tvalid}, 2'b00);

        // Flush in SEND with only the dividend accepted
        dvd_tready = 1'b1;
        start_op(1'b1, 32'd6, 32'd3);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_ins();
        chk("t7_drain_tv", {dvd_tvalid, dvs_tvalid}, 2'b01);
        dvs_tready = 1'b1;
        step();
        chk("t7_drain_done", {dvd_tvalid, dvs_tvalid}, 2'b00);
        give_result({32'd2, 32'd0});
        chk("t7_nowrite", {hi_we, lo_we}, 2'b00);
        chk("t7_lo_kept", lo_wdata, 32'd4);

        // Asynchronous reset in SEND with the dividend accepted
        dvd_tready = 1'b1;
        dvs_tready = 1'b0;
        start_op(1'b1, 32'd20, 32'd4);
        step();
        step();
        chk("t8_partial", {dvd_tvalid, dvs_tvalid}, 2'b01);
        #2 reset = 1'b1;
        #1 chk("t8_rst_ctrl", {dvd_tvalid, dvs_tvalid, hi_we, lo_we, div_signed}, 5'b00000);
        chk("t8_rst_data", {dvd_tdata, dvs_tdata, hi_wdata, lo_wdata}, 128'd0);
        #2 reset = 1'b0;
        clear_ins();
        step();
        give_result({32'd5, 32'd0});
        chk("t8_stray_we", {hi_we, lo_we}, 2'b00);
        chk("t8_stray_lo", lo_wdata, 32'd0);
        chk("t8_idle_tv", {dvd_tvalid, dvs_tvalid}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
